// File: rtl/hex_disp_sched.sv
// Round-robin scheduler sharing one 4-digit hex display among four
// requesters, with a minimum dwell per winner and a digit-scan pacer.
module hex_disp_sched #(
  parameter int DWELL_CYCLES = 50000000,
  parameter int SCAN_DIV     = 50000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  req,
  input  logic [63:0] req_nums,
  output logic [15:0] num,
  output logic [1:0]  owner,
  output logic        owner_valid,
  output logic [3:0]  grant,
  output logic        scan_tick
);

  localparam int DW = $clog2(DWELL_CYCLES);
  localparam int SW = $clog2(SCAN_DIV);
  localparam logic [DW-1:0] DWELL_MAX = DW'(DWELL_CYCLES - 1);
  localparam logic [SW-1:0] SCAN_MAX  = SW'(SCAN_DIV - 1);

  typedef enum logic {IDLE, SHOW} state_e;

  state_e        state_q, state_d;
  logic [1:0]    owner_q, owner_d;
  logic [1:0]    last_q, last_d;
  logic [15:0]   num_q, num_d;
  logic [3:0]    grant_q, grant_d;
  logic [DW-1:0] dwell_q, dwell_d;
  logic [SW-1:0] scan_q, scan_d;
  logic          tick_q, tick_d;

  logic [1:0]  win;
  logic        take;
  logic [3:0]  others;
  logic [15:0] own_num;

  // Scan candidates last+3 down to last+1 so the nearest one wins.
  function automatic logic [1:0] rr_pick(
    input logic [1:0] last,
    input logic [3:0] r
  );
    logic [1:0] c;
    logic [1:0] w;
    w = last;
    for (int k = 3; k >= 1; k--) begin
      c = last + 2'(k);
      if (r[c]) w = c;
    end
    return w;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      owner_q <= '0;
      last_q  <= 2'd3;
      num_q   <= '0;
      grant_q <= '0;
      dwell_q <= '0;
      scan_q  <= '0;
      tick_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      num_q   <= num_d;
      grant_q <= grant_d;
      dwell_q <= dwell_d;
      scan_q  <= scan_d;
      tick_q  <= tick_d;
    end
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    num_d   = num_q;
    dwell_d = dwell_q;
    grant_d = '0;
    take    = 1'b0;
    win     = rr_pick(last_q, req);
    others  = req & ~(4'b0001 << owner_q);
    own_num = req_nums[{owner_q, 4'b0000} +: 16];

    unique case (state_q)
      IDLE: take = |req;
      SHOW: begin
        if (dwell_q == DWELL_MAX) begin
          if (|others) begin
            take = 1'b1;
          end else if (req[owner_q]) begin
            num_d = own_num;
          end else begin
            state_d = IDLE;
          end
        end else begin
          dwell_d = dwell_q + DW'(1);
          if (req[owner_q]) num_d = own_num;
        end
      end
      default: state_d = IDLE;
    endcase

    if (take) begin
      state_d = SHOW;
      owner_d = win;
      last_d  = win;
      grant_d = 4'b0001 << win;
      dwell_d = '0;
      num_d   = req_nums[{win, 4'b0000} +: 16];
    end

    // Tick is registered from terminal count: first pulse after edge SCAN_DIV.
    tick_d = (scan_q == SCAN_MAX);
    scan_d = (scan_q == SCAN_MAX) ? '0 : scan_q + SW'(1);
  end

  always_comb begin
    num         = num_q;
    owner       = owner_q;
    owner_valid = (state_q == SHOW);
    grant       = grant_q;
    scan_tick   = tick_q;
  end

endmodule

// File: tb/tb_hex_disp_sched.sv
// Checks hex_disp_sched cycle by cycle against a behavioural model,
// using directed scenarios followed by randomized request traffic.
module tb_hex_disp_sched;

  localparam int DWELL = 8;
  localparam int SDIV  = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  req = '0;
  logic [63:0] req_nums = '0;
  logic [15:0] num;
  logic [1:0]  owner;
  logic        owner_valid;
  logic [3:0]  grant;
  logic        scan_tick;

  hex_disp_sched #(.DWELL_CYCLES(DWELL), .SCAN_DIV(SDIV)) dut (
    .clk(clk),
    .rst(rst),
    .req(req),
    .req_nums(req_nums),
    .num(num),
    .owner(owner),
    .owner_valid(owner_valid),
    .grant(grant),
    .scan_tick(scan_tick)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  bit          m_show;
  int          m_owner, m_last, m_dwell, m_edges;
  logic [15:0] m_num;
  logic [3:0]  m_grant;
  bit          m_tick;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_show = 0; m_owner = 0; m_last = 3; m_dwell = 0;
    m_edges = 0; m_num = '0; m_grant = '0; m_tick = 0;
  endtask

  function automatic int pick(input int last, input logic [3:0] r);
    for (int k = 1; k <= 4; k++)
      if (r[(last + k) % 4]) return (last + k) % 4;
    return last;
  endfunction

  task automatic take_screen(input int w, input logic [63:0] v);
    m_show = 1; m_owner = w; m_last = w; m_dwell = 0;
    m_grant = 4'(1 << w);
    m_num = v[16*w +: 16];
  endtask

  // Advance the model by one rising edge given the inputs seen at it.
  task automatic model_edge(input logic [3:0] r, input logic [63:0] v);
    logic [3:0] oth;
    m_edges++;
    m_tick = (m_edges % SDIV == 0);
    m_grant = '0;
    oth = r & ~4'(1 << m_owner);
    if (!m_show) begin
      if (r != 0) take_screen(pick(m_last, r), v);
    end else if (m_dwell == DWELL - 1) begin
      if (oth != 0) take_screen(pick(m_last, r), v);
      else if (r[m_owner]) m_num = v[16*m_owner +: 16];
      else m_show = 0;
    end else begin
      m_dwell++;
      if (r[m_owner]) m_num = v[16*m_owner +: 16];
    end
  endtask

  task automatic check_all();
    chk("num", 32'(num), 32'(m_num));
    chk("owner", 32'(owner), 32'(m_owner));
    chk("owner_valid", 32'(owner_valid), 32'(m_show));
    chk("grant", 32'(grant), 32'(m_grant));
    chk("scan_tick", 32'(scan_tick), 32'(m_tick));
  endtask

  task automatic step(input logic [3:0] r, input logic [63:0] v);
    req = r;
    req_nums = v;
    model_edge(r, v);
    @(posedge clk);
    @(negedge clk);
    check_all();
  endtask

  task automatic reset_now();
    #2 rst = 1'b1;
    #1 model_reset();
    check_all();
    @(negedge clk);
    rst = 1'b0;
  endtask

  logic [63:0] v;
  logic [3:0]  r;

  initial begin
    model_reset();
    @(negedge clk);
    check_all();
    rst = 1'b0;

    // Idle display, scan pacing only.
    for (int i = 0; i < 12; i++) step(4'b0000, '0);

    // Single requester, then value tracking.
    v = {48'h0, 16'h1234};
    step(4'b0001, v);
    v = {48'h0, 16'h00AB};
    for (int i = 0; i < 2; i++) step(4'b0001, v);

    // Contention arrives mid-dwell; owner keeps screen until expiry.
    v = {16'h0, 16'hBEEF, 16'h0, 16'h00AB};
    for (int i = 0; i < 14; i++) step(4'b0101, v);
    for (int i = 0; i < 10; i++) step(4'b0000, v);

    // All four requesting: rotating grants.
    v = {16'h3333, 16'h2222, 16'h1111, 16'h0000};
    for (int i = 0; i < 44; i++) step(4'b1111, v);
    for (int i = 0; i < 10; i++) step(4'b0000, v);

    // Owner drops request early: frozen value, then idle.
    v = {16'h0, 16'h0, 16'h5A5A, 16'h0};
    for (int i = 0; i < 4; i++) step(4'b0010, v);
    v = {16'h0, 16'h0, 16'hFFFF, 16'h0};
    for (int i = 0; i < 10; i++) step(4'b0000, v);

    // Reset while requester 3 owns the display.
    v = {16'hC0DE, 48'h0};
    for (int i = 0; i < 3; i++) step(4'b1000, v);
    reset_now();
    for (int i = 0; i < 3; i++) step(4'b1000, v);

    // Randomized traffic.
    r = '0;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 5) == 0) r = 4'($urandom_range(0, 15));
      v = {$urandom, $urandom};
      step(r, v);
      if (i == 700) reset_now();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
